// File: rtl/popcnt_pkg.sv
// popcnt_pkg: shared types and widths for the popcount frame accumulator.
package popcnt_pkg;
    typedef enum logic [1:0] {IDLE, ACC, HOLD} pfa_state_t;
    localparam int POPCNT_W = 2;
    localparam int LEN_W = 8;
endpackage

// File: rtl/popcnt_sat_add.sv
// popcnt_sat_add: SUM_W accumulator plus 2-bit addend with carry out.
// POPCNT_FRAME_ACC_SAT_EN selects saturation at all-ones instead of wrap.
module popcnt_sat_add
    import popcnt_pkg::*;
#(
    parameter int SUM_W = 8
) (
    input  logic [SUM_W-1:0]    acc,
    input  logic [POPCNT_W-1:0] addend,
    output logic [SUM_W-1:0]    sum,
    output logic                carry
);
    logic [SUM_W:0] raw;
    assign raw = {1'b0, acc} + {{(SUM_W + 1 - POPCNT_W){1'b0}}, addend};
    assign carry = raw[SUM_W];
`ifdef POPCNT_FRAME_ACC_SAT_EN
    // Once pinned at all-ones, any further nonzero addend carries again and stays pinned.
    assign sum = carry ? '1 : raw[SUM_W-1:0];
`else
    assign sum = raw[SUM_W-1:0];
`endif
endmodule

// File: rtl/popcnt_frame_acc.sv
// popcnt_frame_acc: accumulates 2-bit counts per frame and holds the total until taken.
// Overflow behaviour is chosen inside popcnt_sat_add via POPCNT_FRAME_ACC_SAT_EN.
module popcnt_frame_acc
    import popcnt_pkg::*;
#(
    parameter int SUM_W   = 8,
    parameter int MAX_LEN = 16
) (
    input  logic                Clk,
    input  logic                Rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [POPCNT_W-1:0] in_data,
    input  logic                in_last,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SUM_W-1:0]    out_sum,
    output logic [LEN_W-1:0]    out_len,
    output logic                out_ovf,
    output logic                out_trunc
);
    pfa_state_t state, state_nx;
    logic [SUM_W-1:0] acc, acc_nx;
    logic [LEN_W-1:0] len, len_nx;
    logic ovf, carry, accept, at_max, close;

    popcnt_sat_add #(.SUM_W(SUM_W)) u_add (
        .acc    (acc),
        .addend (in_data),
        .sum    (acc_nx),
        .carry  (carry)
    );

    assign accept = in_valid & in_ready;
    assign len_nx = len + 1'b1;
    assign at_max = len_nx == LEN_W'(MAX_LEN);
    assign close  = accept & (in_last | at_max);

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) state <= IDLE;
        else state <= state_nx;

    always_comb
        state_nx = state == HOLD ? (out_ready ? IDLE : HOLD) :
                   close         ? HOLD :
                   accept        ? ACC  : state;

    always_comb begin
        in_ready  = state != HOLD;
        out_valid = state == HOLD;
    end

    // Running frame state; cleared as the result is handed off.
    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            acc <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (state == HOLD && out_ready) begin
            acc <= '0;
            len <= '0;
            ovf <= 1'b0;
        end else if (accept) begin
            acc <= acc_nx;
            len <= len_nx;
            ovf <= ovf | carry;
        end

    always_ff @(posedge Clk or negedge Rst_n)
        if (!Rst_n) begin
            out_sum   <= '0;
            out_len   <= '0;
            out_ovf   <= 1'b0;
            out_trunc <= 1'b0;
        end else if (close) begin
            out_sum   <= acc_nx;
            out_len   <= len_nx;
            out_ovf   <= ovf | carry;
            out_trunc <= at_max & ~in_last;
        end
endmodule
